// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues to a 1-cycle imem and buffers words with their PC.
// Define FETCH_STATS_EN to add the stat_fetched / stat_flushed saturating counters.
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              IBUF_DEPTH = 4
) (
  input  logic            clk,
  input  logic            Reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     Instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]     stat_fetched,
  output logic [31:0]     stat_flushed
`endif
);

  localparam int              IW         = $clog2(IBUF_DEPTH);
  localparam int              CW         = IW + 1;
  localparam logic [31:0]     NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pend_pc;
  logic            pending;
  logic [IW-1:0]   wr_ptr;
  logic [IW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   credit;
  logic            issue;
  logic            push;
  logic            pop;

  logic [31:0]     buf_instr [IBUF_DEPTH];
  logic [XLEN-1:0] buf_pc    [IBUF_DEPTH];

  // Credits include the in-flight fetch so a returned word always has a slot.
  assign credit = count + CW'(pending);
  assign issue  = Reset & ~redirect & (credit < CW'(IBUF_DEPTH));
  assign push   = pending & ~redirect;
  assign pop    = (count != '0) & instr_ready & ~redirect;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      fetch_pc <= RESET_PC;
      pend_pc  <= '0;
      pending  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      // Dropping pending here discards the response arriving in the redirect cycle.
      fetch_pc <= redirect_target & ALIGN_MASK;
      pending  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      pending <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + XLEN'(4);
        pend_pc  <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + IW'(1);
      if (pop)  rd_ptr <= rd_ptr + IW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (Reset && push) begin
      buf_instr[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]    <= pend_pc;
    end
  end

  assign imem_req    = issue;
  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != '0);
  assign Instr       = instr_valid ? buf_instr[rd_ptr] : NOP;
  assign instr_pc    = instr_valid ? buf_pc[rd_ptr]    : '0;

`ifdef FETCH_STATS_EN
  logic [32:0] fetched_sum;
  logic [32:0] flushed_sum;

  assign fetched_sum = {1'b0, stat_fetched} + 33'(push);
  assign flushed_sum = {1'b0, stat_flushed} + 33'(count) + 33'(pending);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
    end else begin
      if (push)
        stat_fetched <= fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
      if (redirect)
        stat_flushed <= flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: startup latency, stall fill, redirect flush, PC wrap and async reset.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        Reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_target;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_flushed;
`endif

  int n_vec = 0;
  int n_err = 0;

  fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .IBUF_DEPTH(4)) dut (
    .clk             (clk),
    .Reset           (Reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .Instr           (Instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched    (stat_fetched),
    .stat_flushed    (stat_flushed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Synchronous imem: data for an issued address is valid the next cycle, junk otherwise.
  always @(posedge clk)
    imem_rdata <= imem_req ? word_of(imem_addr) : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Leaves the bench 3 time units after an edge, in the first cycle after reset release (C0).
  task automatic do_reset();
    Reset = 1'b0;
    redirect = 1'b0;
    redirect_target = '0;
    repeat (2) tick();
    Reset = 1'b1;
    #1;
  endtask

  initial begin
    Reset = 1'b0;
    instr_ready = 1'b1;
    redirect = 1'b0;
    redirect_target = '0;
    repeat (2) tick();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", Instr, NOP);
    check("rst_pc", instr_pc, 32'd0);
`ifdef FETCH_STATS_EN
    check("rst_fetched", stat_fetched, 32'd0);
    check("rst_flushed", stat_flushed, 32'd0);
`endif

    // startup latency and steady streaming
    Reset = 1'b1;
    #1;
    check("t1_req0", {31'b0, imem_req}, 32'd1);
    check("t1_addr0", imem_addr, 32'h100);
    check("t1_valid0", {31'b0, instr_valid}, 32'd0);
    tick();
    check("t1_addr1", imem_addr, 32'h104);
    check("t1_valid1", {31'b0, instr_valid}, 32'd0);
    tick();
    check("t1_valid2", {31'b0, instr_valid}, 32'd1);
    check("t1_pc2", instr_pc, 32'h100);
    check("t1_instr2", Instr, word_of(32'h100));
    check("t1_addr2", imem_addr, 32'h108);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t1_pc", instr_pc, 32'h104 + 32'(4 * k));
      check("t1_instr", Instr, word_of(32'h104 + 32'(4 * k)));
      check("t1_addr", imem_addr, 32'h10C + 32'(4 * k));
    end

    // stall: fill exactly DEPTH entries, then drain in order
    instr_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      check("t2_req_on", {31'b0, imem_req}, 32'd1);
      check("t2_addr", imem_addr, 32'h100 + 32'(4 * c));
      tick();
    end
    for (int c = 4; c < 10; c++) begin
      check("t2_req_off", {31'b0, imem_req}, 32'd0);
      check("t2_head", instr_pc, 32'h100);
      tick();
    end
    instr_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      check("t2_valid", {31'b0, instr_valid}, 32'd1);
      check("t2_pop_pc", instr_pc, 32'h100 + 32'(4 * k));
      check("t2_pop_instr", Instr, word_of(32'h100 + 32'(4 * k)));
      if (k == 1) begin
        check("t2_resume_req", {31'b0, imem_req}, 32'd1);
        check("t2_resume_addr", imem_addr, 32'h110);
      end
      tick();
    end

    // redirect with 3 buffered + 1 in flight, while stalled
    instr_ready = 1'b0;
    do_reset();
    repeat (4) tick();
    check("t3_pre_pc", instr_pc, 32'h100);
    redirect = 1'b1;
    redirect_target = 32'h2002;
    #1;
    check("t3_req_R", {31'b0, imem_req}, 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    check("t3_valid_R1", {31'b0, instr_valid}, 32'd0);
    check("t3_req_R1", {31'b0, imem_req}, 32'd1);
    check("t3_addr_R1", imem_addr, 32'h2000);
`ifdef FETCH_STATS_EN
    check("t3_flushed", stat_flushed, 32'd4);
    check("t3_fetched", stat_fetched, 32'd3);
`endif
    tick();
    check("t3_valid_R2", {31'b0, instr_valid}, 32'd0);
    check("t3_addr_R2", imem_addr, 32'h2004);
    tick();
    check("t3_valid_R3", {31'b0, instr_valid}, 32'd1);
    check("t3_pc_R3", instr_pc, 32'h2000);
    check("t3_instr_R3", Instr, word_of(32'h2000));

    // back-to-back redirects: the second one wins
    redirect = 1'b1;
    redirect_target = 32'h3000;
    #1;
    tick();
    redirect_target = 32'h4008;
    #1;
    tick();
    redirect = 1'b0;
    #1;
    check("t3b_addr", imem_addr, 32'h4008);
    check("t3b_valid", {31'b0, instr_valid}, 32'd0);
    repeat (2) tick();
    check("t3b_pc", instr_pc, 32'h4008);

    // PC wrap at the top of the address space
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_target = 32'hFFFF_FFFE;
    #1;
    tick();
    redirect = 1'b0;
    #1;
    check("t4_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("t4_addr_wrap", imem_addr, 32'h0000_0000);
    tick();
    check("t4_pc_top", instr_pc, 32'hFFFF_FFFC);
    tick();
    check("t4_pc_wrap", instr_pc, 32'h0000_0000);
    check("t4_instr_wrap", Instr, word_of(32'h0));

    // async reset mid-stream with 2 entries buffered
    instr_ready = 1'b0;
    do_reset();
    repeat (3) tick();
    check("t5_pre_valid", {31'b0, instr_valid}, 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    check("t5_valid", {31'b0, instr_valid}, 32'd0);
    check("t5_req", {31'b0, imem_req}, 32'd0);
    check("t5_instr", Instr, NOP);
    check("t5_pc", instr_pc, 32'd0);
    tick();
    Reset = 1'b1;
    #1;
    check("t5_restart_req", {31'b0, imem_req}, 32'd1);
    check("t5_restart_addr", imem_addr, RST_PC);
    tick();
    check("t5_no_stale", {31'b0, instr_valid}, 32'd0);
    tick();
    check("t5_first_pc", instr_pc, RST_PC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
